// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM states,
// parity-mode codes, parameter legality limits and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned DATA_BITS_MIN    = 5;
    localparam int unsigned DATA_BITS_MAX    = 9;
    localparam int unsigned STOP_BITS_MIN    = 1;
    localparam int unsigned STOP_BITS_MAX    = 2;
    localparam int unsigned CLKS_PER_BIT_MIN = 1;

    // Unused upper bits of data must be zero so they do not disturb the parity.
    function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_frame_gen_if.sv
// Request/status bundle between a word source and the UART transmitter.
interface uart_tx_frame_gen_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 in_Tx_En;
    logic [DATA_BITS-1:0] in_Tx_Data;
    logic [1:0]           in_Parity_Mode;
    logic                 out_Tx_Ready;
    logic                 out_Tx_Active;
    logic                 out_Tx_Serial;
    logic                 out_Tx_Done;

    modport master (
        output in_Tx_En, in_Tx_Data, in_Parity_Mode,
        input  out_Tx_Ready, out_Tx_Active, out_Tx_Serial, out_Tx_Done
    );

    modport slave (
        input  in_Tx_En, in_Tx_Data, in_Parity_Mode,
        output out_Tx_Ready, out_Tx_Active, out_Tx_Serial, out_Tx_Done
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick_o marks the last clock of each serial bit;
// held at zero while restart_i is high so a new frame starts on a clean period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);
    localparam int unsigned   CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/uart_tx_frame_gen.sv
// Parametrised UART transmitter: start + DATA_BITS (LSB first) + optional parity + stop bits.
// Define UART_TX_PARITY_EN to build the parity stage; otherwise in_Parity_Mode is ignored.
module uart_tx_frame_gen
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic                in_UART_Clock,
    input logic                in_UART_Reset,
    uart_tx_frame_gen_if.slave tx
);
    localparam int unsigned   BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if ((DATA_BITS < DATA_BITS_MIN) || (DATA_BITS > DATA_BITS_MAX) ||
            (STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX) ||
            (CLKS_PER_BIT < CLKS_PER_BIT_MIN)) begin : g_bad_params
            $error("uart_tx_frame_gen: illegal DATA_BITS/STOP_BITS/CLKS_PER_BIT");
        end
    endgenerate

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [BW-1:0]        bit_q;
    logic                 stop_q;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;
    logic                 ready_q;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_val_q;
    logic par_en_d, par_val_d;
    assign par_en_d  = (tx.in_Parity_Mode == PAR_EVEN) || (tx.in_Parity_Mode == PAR_ODD);
    assign par_val_d = parity_bit(9'(tx.in_Tx_Data), tx.in_Parity_Mode);
`else
    logic unused_mode;
    assign unused_mode = ^tx.in_Parity_Mode;
`endif

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i     (in_UART_Clock),
        .rst_i     (in_UART_Reset),
        .restart_i (state_q == ST_IDLE),
        .tick_o    (bit_end)
    );

    always_ff @(posedge in_UART_Clock) begin
        if (in_UART_Reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_val_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    serial_q <= 1'b1;
                    if (tx.in_Tx_En) begin
                        shreg_q   <= tx.in_Tx_Data;
                        bit_q     <= '0;
                        state_q   <= ST_START;
                        serial_q  <= 1'b0;
                        active_q  <= 1'b1;
                        ready_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= par_en_d;
                        par_val_q <= par_val_d;
`endif
                    end
                end
                // Serial output is loaded one bit ahead so it changes exactly on the bit boundary.
                ST_START: if (bit_end) begin
                    state_q  <= ST_DATA;
                    serial_q <= shreg_q[0];
                    shreg_q  <= shreg_q >> 1;
                end
                ST_DATA: if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_q  <= ST_PARITY;
                            serial_q <= par_val_q;
                        end else begin
                            state_q  <= ST_STOP;
                            serial_q <= 1'b1;
                        end
`else
                        state_q  <= ST_STOP;
                        serial_q <= 1'b1;
`endif
                    end else begin
                        bit_q    <= bit_q + 1'b1;
                        serial_q <= shreg_q[0];
                        shreg_q  <= shreg_q >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: if (bit_end) begin
                    state_q  <= ST_STOP;
                    serial_q <= 1'b1;
                    stop_q   <= 1'b0;
                end
`endif
                ST_STOP: if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_q  <= ST_IDLE;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                    end else begin
                        stop_q <= stop_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    serial_q <= 1'b1;
                    active_q <= 1'b0;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign tx.out_Tx_Serial = serial_q;
    assign tx.out_Tx_Active = active_q;
    assign tx.out_Tx_Done   = done_q;
    assign tx.out_Tx_Ready  = ready_q;
endmodule
